bram_fifo: RTL and testbench
============================

# bram_fifo

Transactional single-clock FIFO backed by one inferred block RAM. It provides per-endpoint buffering in the USB protocol engine: one instance per direction per endpoint. Both sides work in transactions. The writer fills a packet and then commits or discards it. The reader pops a packet and then commits it (space is freed) or rewinds it (the same data is available again for retransmission).

## Interface
- EP_ADDR_WID, default 9: RAM address width. Depth is 2^EP_ADDR_WID words; usable capacity is 2^EP_ADDR_WID − 1 words.
- EP_DATA_WID, default 8: word width.

Ports:
- CLK, input, 1: sole clock; everything is rising-edge.
- RST_N, input, 1: asynchronous, active-low reset.
- dataValid, input, 1: write dataIn at the tentative write pointer.
- fillTransDone, input, 1: end of the fill transaction.
- fillTransSuccess, input, 1: qualifies fillTransDone; 1 = commit, 0 = discard.
- full, output, 1: no free word available for the writer.
- dataIn, input, EP_DATA_WID: write data.
- popData, input, 1: consume the current head word.
- popTransDone, input, 1: end of the pop transaction.
- popTransSuccess, input, 1: qualifies popTransDone; 1 = free the popped words, 0 = rewind.
- dataAvailable, output, 1: a committed, not-yet-popped word is present.
- dataOut, output, EP_DATA_WID: current head word; valid whenever dataAvailable = 1.

## Operation
Four EP_ADDR_WID-bit pointers are kept. All of them wrap modulo 2^EP_ADDR_WID.
- wrPtr: tentative write pointer.
- wrCommit: committed write pointer.
- rdPtr: tentative read pointer.
- rdCommit: committed read pointer.

Derived outputs:
- full = (wrPtr + 1 == rdCommit). Space is freed only when a pop transaction commits.
- dataAvailable = (rdPtr != wrCommit). Only committed data is readable.

Write side:
- dataValid && !full: mem[wrPtr] ← dataIn, then wrPtr++.
- dataValid while full: ignored. There is no write and no pointer change. The caller detects the loss and fails its transaction.
- fillTransDone && fillTransSuccess: wrCommit ← next wrPtr. Any write in the same cycle is included.
- fillTransDone && !fillTransSuccess: wrPtr ← wrCommit. A write in the same cycle is discarded.

Read side:
- popData && dataAvailable: rdPtr++.
- popData while !dataAvailable: ignored.
- popTransDone && popTransSuccess: rdCommit ← next rdPtr. A pop in the same cycle is included.
- popTransDone && !popTransSuccess: rdPtr ← rdCommit. A pop in the same cycle is discarded.

Read path:
- The RAM read is synchronous, addressed by next-rdPtr (prefetch). After every pop or rewind, dataOut shows the new head word in the following cycle.
- Same-cycle read and write to the same address: write-first bypass, so dataOut returns the newly written dataIn.

The two sides are independent. Any combination of write, pop, fill-done and pop-done in one cycle is legal and is applied together.

Reset (RST_N = 0, asynchronous): all pointers = 0, full = 0, dataAvailable = 0, dataOut = 0. RAM contents are unchanged and don't-care. Reset during a transaction abandons it; no partial commit survives.

## Timing
- Write to committed visibility: dataAvailable can rise no earlier than the cycle after the fillTransDone/success edge.
- Pop latency:
  - dataAvailable and dataOut update in the cycle after the popData edge.
  - Back-to-back pops every cycle are supported, with dataOut streaming one word per cycle.
- full updates in the cycle after:
  - the write that fills the last free word;
  - a pop commit that frees space;
  - a discard that rewinds wrPtr.
- Throughput: one write and one pop per cycle, concurrently.
- All outputs are registered or derived combinationally from registered pointers. There are no combinational input-to-output paths except via the RAM bypass, which is registered.

## Structure
- Single module; the RAM is inferred inside it as reg [EP_DATA_WID-1:0] mem[2^EP_ADDR_WID] with one synchronous write port and one synchronous read port.
- No sub-module is needed.
- No package types are required. A shared package may hold the default EP_ADDR_WID/EP_DATA_WID constants used by usb_pe.

## Test plan
- Reset, then fill 3 bytes 0xA1, 0xA2, 0xA3 and commit. Pop them. Required: dataOut = A1/A2/A3 in order, then dataAvailable = 0, and full = 0 throughout.
- Fill 2 bytes, then fillTransDone with success = 0. Required: dataAvailable stays 0. The next committed fill of 0x55 reads back as 0x55 at the original address.
- Commit 4 bytes, pop 2, then popTransDone with success = 0. Required: dataOut returns to byte 0 and all 4 bytes are re-readable. Repeating with success = 1 frees the space.
- Write 2^EP_ADDR_WID − 1 bytes (511 with defaults). Required: full = 1 afterwards, and a 512th write is ignored. After commit, pop all and pop-commit. Required: full = 0, and the pointers wrap so the next fill works.
- Same-cycle dataValid (0x77) plus fillTransDone/success into an empty FIFO. Required: the next cycle dataAvailable = 1 and dataOut = 0x77 (bypass).
- Assert RST_N low mid-fill and mid-pop. Required: all outputs go to 0 immediately (asynchronously), and uncommitted data is lost.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// ============================================================================
// Module      : bram_fifo_pkg
// Description : Default endpoint buffer geometry shared by bram_fifo and usb_pe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_fifo_pkg;

    localparam int c_EP_ADDR_WID = 9;
    localparam int c_EP_DATA_WID = 8;

endpackage : bram_fifo_pkg

`default_nettype wire

// File: rtl/bram_fifo.sv
// ============================================================================
// Module      : bram_fifo
// Description : Transactional single-clock FIFO on one inferred block RAM;
//               writer commits/discards packets, reader commits/rewinds them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int EP_ADDR_WID = c_EP_ADDR_WID,
    parameter int EP_DATA_WID = c_EP_DATA_WID
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   dataValid,
    input  logic                   fillTransDone,
    input  logic                   fillTransSuccess,
    output logic                   full,
    input  logic [EP_DATA_WID-1:0] dataIn,
    input  logic                   popData,
    input  logic                   popTransDone,
    input  logic                   popTransSuccess,
    output logic                   dataAvailable,
    output logic [EP_DATA_WID-1:0] dataOut
);

    localparam int                     c_DEPTH   = 2 ** EP_ADDR_WID;
    localparam logic [EP_ADDR_WID-1:0] c_PTR_ONE = EP_ADDR_WID'(1);

    logic [EP_DATA_WID-1:0] r_mem [c_DEPTH];

    logic [EP_ADDR_WID-1:0] r_wrPtr;
    logic [EP_ADDR_WID-1:0] r_wrCommit;
    logic [EP_ADDR_WID-1:0] r_rdPtr;
    logic [EP_ADDR_WID-1:0] r_rdCommit;
    logic [EP_DATA_WID-1:0] r_ramQ;
    logic [EP_DATA_WID-1:0] r_bypassData;
    logic                   r_bypassSel;
    logic                   r_outEn;

    logic                   w_doWrite;
    logic                   w_doPop;
    logic                   w_bypass;
    logic [EP_ADDR_WID-1:0] w_wrPtrInc;
    logic [EP_ADDR_WID-1:0] w_rdPtrInc;
    logic [EP_ADDR_WID-1:0] w_wrPtrAdv;
    logic [EP_ADDR_WID-1:0] w_rdPtrAdv;
    logic [EP_ADDR_WID-1:0] w_wrPtrNext;
    logic [EP_ADDR_WID-1:0] w_wrCommitNext;
    logic [EP_ADDR_WID-1:0] w_rdPtrNext;
    logic [EP_ADDR_WID-1:0] w_rdCommitNext;

    assign w_wrPtrInc    = r_wrPtr + c_PTR_ONE;
    assign w_rdPtrInc    = r_rdPtr + c_PTR_ONE;

    // One slot is always left empty so full and empty stay distinguishable.
    assign full          = (w_wrPtrInc == r_rdCommit);
    assign dataAvailable = (r_rdPtr != r_wrCommit);

    assign w_doWrite     = dataValid & ~full;
    assign w_doPop       = popData & dataAvailable;
    assign w_wrPtrAdv    = w_doWrite ? w_wrPtrInc : r_wrPtr;
    assign w_rdPtrAdv    = w_doPop   ? w_rdPtrInc : r_rdPtr;

    always_comb begin
        w_wrPtrNext    = w_wrPtrAdv;
        w_wrCommitNext = r_wrCommit;
        if (fillTransDone) begin
            if (fillTransSuccess) begin
                w_wrCommitNext = w_wrPtrAdv;
            end else begin
                w_wrPtrNext = r_wrCommit;
            end
        end
    end

    always_comb begin
        w_rdPtrNext    = w_rdPtrAdv;
        w_rdCommitNext = r_rdCommit;
        if (popTransDone) begin
            if (popTransSuccess) begin
                w_rdCommitNext = w_rdPtrAdv;
            end else begin
                w_rdPtrNext = r_rdCommit;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wrPtr    <= '0;
            r_wrCommit <= '0;
            r_rdPtr    <= '0;
            r_rdCommit <= '0;
        end else begin
            r_wrPtr    <= w_wrPtrNext;
            r_wrCommit <= w_wrCommitNext;
            r_rdPtr    <= w_rdPtrNext;
            r_rdCommit <= w_rdCommitNext;
        end
    end

    // RAM prefetches the next head every cycle so dataOut follows pops/rewinds.
    always_ff @(posedge CLK) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr] <= dataIn;
        end
        r_ramQ <= r_mem[w_rdPtrNext];
    end

    // Write-first behaviour for a same-cycle write to the prefetched address.
    assign w_bypass = w_doWrite & (r_wrPtr == w_rdPtrNext);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bypassSel  <= 1'b0;
            r_bypassData <= '0;
            r_outEn      <= 1'b0;
        end else begin
            r_bypassSel  <= w_bypass;
            r_bypassData <= dataIn;
            r_outEn      <= 1'b1;
        end
    end

    assign dataOut = !r_outEn    ? '0           :
                     r_bypassSel ? r_bypassData :
                                   r_ramQ;

endmodule : bram_fifo

`default_nettype wire

// File: tb/tb_bram_fifo.sv
// ============================================================================
// Module      : tb_bram_fifo
// Description : Directed self-checking bench for bram_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_fifo;

    logic       CLK;
    logic       RST_N;
    logic       dataValid;
    logic       fillTransDone;
    logic       fillTransSuccess;
    logic       full;
    logic [7:0] dataIn;
    logic       popData;
    logic       popTransDone;
    logic       popTransSuccess;
    logic       dataAvailable;
    logic [7:0] dataOut;

    int errors = 0;
    int checks = 0;

    bram_fifo #(
        .EP_ADDR_WID (9),
        .EP_DATA_WID (8)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .dataValid        (dataValid),
        .fillTransDone    (fillTransDone),
        .fillTransSuccess (fillTransSuccess),
        .full             (full),
        .dataIn           (dataIn),
        .popData          (popData),
        .popTransDone     (popTransDone),
        .popTransSuccess  (popTransSuccess),
        .dataAvailable    (dataAvailable),
        .dataOut          (dataOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; returns 1 time unit after the active edge.
    task automatic cyc(input logic dv, input logic [7:0] din, input logic fd, input logic fs,
                       input logic pd, input logic ptd, input logic pts);
        dataValid        = dv;
        dataIn           = din;
        fillTransDone    = fd;
        fillTransSuccess = fs;
        popData          = pd;
        popTransDone     = ptd;
        popTransSuccess  = pts;
        @(posedge CLK);
        #1;
        dataValid        = 1'b0;
        dataIn           = 8'h00;
        fillTransDone    = 1'b0;
        fillTransSuccess = 1'b0;
        popData          = 1'b0;
        popTransDone     = 1'b0;
        popTransSuccess  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        dataValid = 1'b0; dataIn = 8'h00; fillTransDone = 1'b0; fillTransSuccess = 1'b0;
        popData = 1'b0; popTransDone = 1'b0; popTransSuccess = 1'b0;
        #3;
        check("rst_full",  16'(full), 16'h0);
        check("rst_avail", 16'(dataAvailable), 16'h0);
        check("rst_dout",  16'(dataOut), 16'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);

        // Basic fill/commit/pop
        cyc(1, 8'hA1, 0, 0, 0, 0, 0);
        check("pre_commit_avail", 16'(dataAvailable), 16'h0);
        cyc(1, 8'hA2, 0, 0, 0, 0, 0);
        cyc(1, 8'hA3, 1, 1, 0, 0, 0);
        check("basic_avail", 16'(dataAvailable), 16'h1);
        check("basic_d0", 16'(dataOut), 16'hA1);
        check("basic_full", 16'(full), 16'h0);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("basic_d1", 16'(dataOut), 16'hA2);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("basic_d2", 16'(dataOut), 16'hA3);
        cyc(0, 8'h00, 0, 0, 1, 1, 1);
        check("basic_empty", 16'(dataAvailable), 16'h0);
        check("basic_full_end", 16'(full), 16'h0);

        // Discarded fill, then commit at the original address
        cyc(1, 8'h11, 0, 0, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        check("discard_avail", 16'(dataAvailable), 16'h0);
        cyc(1, 8'h55, 1, 1, 0, 0, 0);
        check("after_discard_avail", 16'(dataAvailable), 16'h1);
        check("after_discard_d", 16'(dataOut), 16'h55);
        cyc(0, 8'h00, 0, 0, 1, 1, 1);
        check("after_discard_empty", 16'(dataAvailable), 16'h0);

        // Pop rewind then pop commit
        cyc(1, 8'h10, 0, 0, 0, 0, 0);
        cyc(1, 8'h20, 0, 0, 0, 0, 0);
        cyc(1, 8'h30, 0, 0, 0, 0, 0);
        cyc(1, 8'h40, 1, 1, 0, 0, 0);
        check("rw_d0", 16'(dataOut), 16'h10);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("rw_d1", 16'(dataOut), 16'h20);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("rw_d2", 16'(dataOut), 16'h30);
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        check("rw_rewound", 16'(dataOut), 16'h10);
        check("rw_avail", 16'(dataAvailable), 16'h1);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("rw_re1", 16'(dataOut), 16'h20);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("rw_re2", 16'(dataOut), 16'h30);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("rw_re3", 16'(dataOut), 16'h40);
        cyc(0, 8'h00, 0, 0, 1, 1, 1);
        check("rw_empty", 16'(dataAvailable), 16'h0);

        // Fill to capacity (511), overflow ignored, drain, wrap
        for (int i = 0; i < 511; i++) begin
            cyc(1, i[7:0], 0, 0, 0, 0, 0);
            if (i == 509) check("cap_not_full_510", 16'(full), 16'h0);
        end
        check("cap_full", 16'(full), 16'h1);
        cyc(1, 8'hEE, 0, 0, 0, 0, 0);
        check("cap_full_after_extra", 16'(full), 16'h1);
        check("cap_uncommitted", 16'(dataAvailable), 16'h0);
        cyc(0, 8'h00, 1, 1, 0, 0, 0);
        check("cap_avail", 16'(dataAvailable), 16'h1);
        for (int i = 0; i < 511; i++) begin
            check("cap_stream", 16'(dataOut), 16'(i[7:0]));
            cyc(0, 8'h00, 0, 0, 1, (i == 510), 1);
        end
        check("cap_drained", 16'(dataAvailable), 16'h0);
        check("cap_freed", 16'(full), 16'h0);
        cyc(1, 8'h5A, 1, 1, 0, 0, 0);
        check("wrap_avail", 16'(dataAvailable), 16'h1);
        check("wrap_d", 16'(dataOut), 16'h5A);
        cyc(0, 8'h00, 0, 0, 1, 1, 1);

        // Same-cycle write + commit into empty FIFO
        cyc(1, 8'h77, 1, 1, 0, 0, 0);
        check("bypass_avail", 16'(dataAvailable), 16'h1);
        check("bypass_d", 16'(dataOut), 16'h77);
        cyc(0, 8'h00, 0, 0, 1, 1, 1);
        check("bypass_empty", 16'(dataAvailable), 16'h0);

        // Asynchronous reset mid-fill and mid-pop
        cyc(1, 8'h33, 0, 0, 0, 0, 0);
        cyc(1, 8'h44, 1, 1, 0, 0, 0);
        cyc(1, 8'h66, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        check("pre_rst_d", 16'(dataOut), 16'h44);
        check("pre_rst_avail", 16'(dataAvailable), 16'h1);
        #1 RST_N = 1'b0;
        #1;
        check("async_rst_avail", 16'(dataAvailable), 16'h0);
        check("async_rst_dout", 16'(dataOut), 16'h0);
        check("async_rst_full", 16'(full), 16'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        check("post_rst_avail", 16'(dataAvailable), 16'h0);
        cyc(0, 8'h00, 1, 1, 0, 0, 0);
        check("post_rst_commit_nothing", 16'(dataAvailable), 16'h0);
        cyc(1, 8'h99, 1, 1, 0, 0, 0);
        check("post_rst_avail2", 16'(dataAvailable), 16'h1);
        check("post_rst_d", 16'(dataOut), 16'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bram_fifo

`default_nettype wire
